exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_if.sv | 26 ++
 rtl/exec_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/exec_sequencer_if.sv
// Instruction handshake, ALU control and completion signals of the execute sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline/bench.
interface exec_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] control_type;
  logic       ctl_valid;
  logic       md_done;
  logic       overflow;
  logic       cond_true;
  logic       done;
  logic       branch_taken;
  logic [1:0] exc_code;

  modport slave (
    input  op_valid, opcode, funct, md_done, overflow, cond_true,
    output op_ready, control_type, ctl_valid, done, branch_taken, exc_code
  );

  modport master (
    output op_valid, opcode, funct, md_done, overflow, cond_true,
    input  op_ready, control_type, ctl_valid, done, branch_taken, exc_code
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: decodes one instruction at a time, drives the ALU control code,
// waits on mult/div or samples ALU flags, then reports completion with exception/branch status.
module exec_sequencer #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  exec_sequencer_if.slave  bus
);

  localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
  localparam logic [4:0] NOP = 5'h1F;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MD,
    CHECK,
    ILLEGAL,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    exc_q, exc_d;
  logic          taken_q, taken_d;

  logic          decIllegal;
  logic [4:0]    decCode;

  // Bit 5 of the result flags an undecodable instruction; bits 4:0 are the control code.
  function automatic logic [5:0] decodeOp(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] r;
    r = 6'h00;
    if (op == 6'h00) begin
      case (fn)
        6'h20:   r[4:0] = 5'h01;
        6'h21:   r[4:0] = 5'h0B;
        6'h22:   r[4:0] = 5'h02;
        6'h24:   r[4:0] = 5'h03;
        6'h25:   r[4:0] = 5'h08;
        6'h2A:   r[4:0] = 5'h07;
        6'h1A:   r[4:0] = 5'h09;
        6'h18:   r[4:0] = 5'h0A;
        6'h10:   r[4:0] = 5'h0C;
        6'h12:   r[4:0] = 5'h0D;
        default: r[5]   = 1'b1;
      endcase
    end else begin
      case (op)
        6'h04:   r[4:0] = 5'h0E;
        6'h05:   r[4:0] = 5'h0F;
        6'h06:   r[4:0] = 5'h10;
        6'h07:   r[4:0] = 5'h11;
        6'h08:   r[4:0] = 5'h01;
        6'h09:   r[4:0] = 5'h0B;
        6'h0F:   r[4:0] = 5'h12;
        default: r[5]   = 1'b1;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    {decIllegal, decCode} = decodeOp(bus.opcode, bus.funct);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= 5'h00;
      cnt_q   <= '0;
      exc_q   <= 2'b00;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      taken_q <= taken_d;
    end
  end

  // The WAIT_MD counter is held at zero outside WAIT_MD, so it is already cleared on entry.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = '0;
    exc_d   = exc_q;
    taken_d = taken_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          code_d  = decCode;
          exc_d   = 2'b00;
          taken_d = 1'b0;
          state_d = decIllegal ? ILLEGAL : ISSUE;
        end
      end
      ISSUE: begin
        if (code_q == 5'h09 || code_q == 5'h0A) begin
          state_d = WAIT_MD;
        end else if (code_q == 5'h01 || code_q == 5'h02 ||
                     (code_q >= 5'h0E && code_q <= 5'h11)) begin
          state_d = CHECK;
        end else begin
          state_d = DONE;
        end
      end
      WAIT_MD: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.md_done) begin
          exc_d   = 2'b00;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          exc_d   = 2'b11;
          state_d = DONE;
        end
      end
      CHECK: begin
        if (code_q == 5'h01 || code_q == 5'h02) begin
          exc_d = bus.overflow ? 2'b01 : 2'b00;
        end
        if (code_q >= 5'h0E && code_q <= 5'h11) begin
          taken_d = bus.cond_true;
        end
        state_d = DONE;
      end
      ILLEGAL: begin
        exc_d   = 2'b10;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset forces them without waiting for a clock.
  always_comb begin
    bus.op_ready     = (state_q == IDLE);
    bus.ctl_valid    = (state_q == ISSUE);
    bus.done         = (state_q == DONE);
    bus.control_type = (state_q == ISSUE || state_q == WAIT_MD || state_q == CHECK) ? code_q : NOP;
    bus.exc_code     = (state_q == DONE) ? exc_q : 2'b00;
    bus.branch_taken = (state_q == DONE) ? taken_q : 1'b0;
  end

endmodule
